mem_port_arbiter: RTL

- Arbitrates the single-ported unified instruction/data memory between the fetch requester (IF) and the load/store requester (MEM stage).
- Sequences each access over a fixed memory latency, returns read data and completion to the winning requester, and prevents fetch starvation.
- Sits between the pipeline front/back ends and the unified memory. It replaces ad-hoc address muxing and PC-freeze logic with an explicit req/gnt/rvalid handshake.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store,
// with fixed-latency sequencing and fetch anti-starvation. Define MISALIGN_CHK_EN to add d_misalign.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MISALIGN_CHK_EN
    ,
    output logic              d_misalign
`endif
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
`ifdef MISALIGN_CHK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               own_data_q, own_data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [2:0]         func3_q, func3_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               misalign_q, misalign_d;

    logic               req_misalign;
    logic               active;
    logic               done;

    assign req_misalign = MISALIGN_EN &&
                          (((d_func3[1:0] == 2'b01) && d_addr[0]) ||
                           ((d_func3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)));

    // Reset masks all outputs, including an in-flight completion.
    assign active = (state_q == ACTIVE) && !rst;
    assign done   = misalign_q || (lat_cnt_q == LAT_W'(MEM_LAT - 1));

    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            if (d_req && (!if_req || (starve_cnt_q < STV_W'(STARVE_MAX)))) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        own_data_d   = own_data_q;
        addr_d       = addr_q;
        we_d         = we_q;
        func3_d      = func3_q;
        wdata_d      = wdata_q;
        misalign_d   = misalign_q;
        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d    = ACTIVE;
                    lat_cnt_d  = '0;
                    own_data_d = 1'b1;
                    addr_d     = d_addr;
                    we_d       = d_we;
                    func3_d    = d_func3;
                    wdata_d    = d_wdata;
                    misalign_d = req_misalign;
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STV_W'(STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_gnt) begin
                    state_d      = ACTIVE;
                    lat_cnt_d    = '0;
                    own_data_d   = 1'b0;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                    func3_d      = 3'b010;
                    wdata_d      = '0;
                    misalign_d   = 1'b0;
                    starve_cnt_d = '0;
                end else if (!if_req) begin
                    starve_cnt_d = '0;
                end
            end
            ACTIVE: begin
                if (done) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            own_data_q   <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            func3_q      <= '0;
            wdata_q      <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            own_data_q   <= own_data_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            wdata_q      <= wdata_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        busy      = 1'b0;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_func3 = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
`ifdef MISALIGN_CHK_EN
        d_misalign = 1'b0;
`endif
        if (active) begin
            busy      = 1'b1;
            mem_addr  = addr_q;
            mem_func3 = func3_q;
            mem_wdata = wdata_q;
            // A misaligned access occupies the slot but never touches memory.
            mem_read  = !we_q && !misalign_q;
            mem_write = we_q && !misalign_q;
            if (done) begin
                if (own_data_q) begin
                    d_rvalid = 1'b1;
                    d_rdata  = (we_q || misalign_q) ? '0 : mem_rdata;
`ifdef MISALIGN_CHK_EN
                    d_misalign = misalign_q;
`endif
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
        end
    end

endmodule
